// File: rtl/mode_arb_pkg.sv
// Shared types and constants for the three-requester mode-code arbiter.
package mode_arb_pkg;

  localparam int NREQ   = 3;
  localparam int CODE_W = 2;

  localparam logic [CODE_W-1:0] CODE_IDLE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // One-hot grant vector for a requester index; out-of-range index gives no grant.
  function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Mode code driven for a requester index: index + 1, so 0 stays reserved for idle.
  function automatic logic [CODE_W-1:0] idx_code(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mode_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward
// from the requester after the last winner, wrapping at 3.
module rr_pick
  import mode_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      win,
  output logic            any
);

  // Priority order rotates so the most recent winner is searched last.
  always_comb begin
    any = |req;
    win = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else if (req[0]) win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else if (req[1]) win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/mode_arbiter.sv
// Round-robin owner arbitration for the shared 2-bit mode code.
// Optional hold timer: define MODE_ARB_HOLD_TIMER_EN to force release of a
// grant after HOLD_MAX cycles when another requester is waiting.
//
// state      | meaning
// ST_IDLE    | no owner, arbitrate every cycle
// ST_GRANT   | r_last owns the code
// ST_RECOVER | one-cycle dead time after a release
module mode_arbiter
  import mode_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              preempt
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_last;
  logic [1:0]          w_last_nxt;
  logic [1:0]          w_win;
  logic                w_any;
  logic                w_owner_req;
  logic                w_force;
  logic [NREQ-1:0]     r_gnt;
  logic [CODE_W-1:0]   r_code;
  logic                r_busy;
  logic                r_preempt;
  logic [NREQ-1:0]     w_gnt_nxt;
  logic [CODE_W-1:0]   w_code_nxt;
  logic                w_busy_nxt;
  logic                w_preempt_nxt;

  rr_pick u_rr_pick (
    .req  (req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  // r_last doubles as the current owner while in ST_GRANT.
  assign w_owner_req = |(req & idx_onehot(r_last));

`ifdef MODE_ARB_HOLD_TIMER_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  logic [3:0] r_hold;
  logic       w_others;

  assign w_others = |(req & ~idx_onehot(r_last));
  assign w_force  = (r_state == ST_GRANT) && w_owner_req && w_others &&
                    (r_hold == HOLD_LAST);

  // Hold counter: cleared at grant start, saturating count of grant cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold <= 4'd0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_GRANT) begin
      r_hold <= 4'd0;
    end else if (r_state == ST_GRANT && r_hold != 4'hF) begin
      r_hold <= r_hold + 4'd1;
    end
  end
`else
  localparam int hold_max_unused = HOLD_MAX;

  assign w_force = 1'b0;
`endif

  // State register and last-winner memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic; other requests are ignored while a grant is held.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_last_nxt  = w_win;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || w_force) w_state_nxt = ST_RECOVER;
      end
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so outputs line up with the state register.
  always_comb begin
    w_gnt_nxt     = '0;
    w_code_nxt    = CODE_IDLE;
    w_busy_nxt    = 1'b0;
    w_preempt_nxt = w_force;
    case (w_state_nxt)
      ST_GRANT: begin
        w_gnt_nxt  = idx_onehot(w_last_nxt);
        w_code_nxt = idx_code(w_last_nxt);
        w_busy_nxt = 1'b1;
      end
      ST_RECOVER: w_busy_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gnt     <= '0;
      r_code    <= CODE_IDLE;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_code    <= w_code_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign code    = r_code;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mode_arbiter.sv
// Scoreboard bench for mode_arbiter: stimulus pushes the reference model's
// expected outputs, a monitor pops and compares one entry per clock.
// Follows MODE_ARB_HOLD_TIMER_EN the same way the design does.
module tb_mode_arbiter;
  import mode_arb_pkg::*;

  localparam int HOLD_MAX = 4;
`ifdef MODE_ARB_HOLD_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req   = 3'b000;
  logic [2:0] gnt;
  logic [1:0] code;
  logic       busy;
  logic       preempt;

  mode_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .code    (code),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] code;
    logic       busy;
    logic       preempt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner index (-1 = none), dead-time flag, last winner, grant age.
  int m_owner;
  int m_last;
  int m_hold;
  bit m_recover;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_owner   = -1;
    m_last    = 2;
    m_hold    = 0;
    m_recover = 1'b0;
  endfunction

  // Outputs expected after the next rising edge given the request level r.
  function automatic exp_t model_step(input logic [2:0] r);
    exp_t e;
    e.gnt = 3'b000; e.code = 2'd0; e.busy = 1'b0; e.preempt = 1'b0;
    if (m_recover) begin
      m_recover = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (r[i]) begin
          m_owner = i;
          m_last  = i;
          m_hold  = 0;
          break;
        end
      end
    end else begin
      bit others;
      others = (r & ~(3'b001 << m_owner)) != 3'b000;
      if (!r[m_owner]) begin
        m_owner   = -1;
        m_recover = 1'b1;
      end else if (TIMER && m_hold == HOLD_MAX - 1 && others) begin
        m_owner   = -1;
        m_recover = 1'b1;
        e.preempt = 1'b1;
      end else if (m_hold < 15) begin
        m_hold++;
      end
    end
    if (m_owner >= 0) begin
      e.gnt  = 3'(1 << m_owner);
      e.code = 2'(m_owner + 1);
      e.busy = 1'b1;
    end else if (m_recover) begin
      e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input logic [2:0] r, input int n);
    repeat (n) begin
      @(negedge clock);
      req = r;
      q.push_back(model_step(r));
    end
  endtask

  // All of base requesting; each owner drops its bit after holding 2 cycles.
  task automatic rotate(input logic [2:0] base, input int n);
    logic [2:0] r;
    repeat (n) begin
      r = base;
      if (m_owner >= 0 && m_hold >= 1) r = base & ~(3'b001 << m_owner);
      drive(r, 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_gnt",     int'(gnt),     0);
    check("rst_code",    int'(code),    0);
    check("rst_busy",    int'(busy),    0);
    check("rst_preempt", int'(preempt), 0);
    model_reset();
    req = 3'b000;
    #2;
    reset = 1'b1;
  endtask

  // Monitor: one expected entry per rising edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt",     int'(gnt),     int'(e.gnt));
        check("code",    int'(code),    int'(e.code));
        check("busy",    int'(busy),    int'(e.busy));
        check("preempt", int'(preempt), int'(e.preempt));
      end
    end
  end

  initial begin
    logic [2:0] r;
    model_reset();
    #12;
    check("init_gnt",  int'(gnt),  0);
    check("init_code", int'(code), 0);
    check("init_busy", int'(busy), 0);
    reset = 1'b1;

    // Single requester 2.
    drive(3'b000, 2);
    drive(3'b100, 5);
    drive(3'b000, 4);

    // Fairness with all three requesting: expect 0, 1, 2, 0.
    do_reset();
    rotate(3'b111, 20);
    drive(3'b000, 3);

    // Wrap-around from last winner 2 with requesters 0 and 2.
    do_reset();
    rotate(3'b101, 12);
    drive(3'b000, 3);

    // Hold timer scenario: requester 1 joins at grant cycle 2.
    do_reset();
    drive(3'b001, 2);
    drive(3'b011, 12);
    drive(3'b000, 4);

    // Reset in the middle of a grant, then requester 1 first.
    do_reset();
    drive(3'b010, 3);
    do_reset();
    drive(3'b010, 3);
    drive(3'b000, 3);

    // Randomized request levels with persistence.
    r = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      drive(r, 1);
    end
    drive(3'b000, 4);

    repeat (3) @(negedge clock);
    check("queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_arbiter.md
# mode_arbiter

Round-robin arbiter that shares the 2-bit output-mode code register between three requesters. Each requester holds `req[i]` to claim the code. The arbiter grants one requester at a time and drives the shared `code` output with that requester's mode value, so downstream mode logic sees exactly one writer. It sits between the requester control blocks and the mode-driven datapath.

## Interface
- `HOLD_MAX`, 4: maximum grant length in cycles when the hold timer is compiled in; legal range 1..15.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input [2:0]: level requests, one bit per requester; held high for as long as the requester wants the code.
- `gnt` output [2:0]: one-hot registered grant; all zeros when no grant is active.
- `code` output [1:0]: registered mode code.
  - 0 means idle.
  - Otherwise the value is granted index + 1.
- `busy` output 1: high in the GRANT and RECOVER states.
- `preempt` output 1: one-cycle pulse when the hold timer forces a release. Tied to 0 when the timer is compiled out.

## Operation
- FSM states:
  - IDLE: no grant; arbitrates every cycle.
  - GRANT: one requester owns the code.
  - RECOVER: one-cycle dead time after any release.
- IDLE → GRANT when any `req` bit is high.
  - Winner is the first set bit, searching upward from (last_winner + 1) mod 3.
  - `last_winner` updates to the winner.
- GRANT → RECOVER when the granted requester's `req` bit is low.
  - Any other `req` bits are ignored during GRANT.
- RECOVER → IDLE unconditionally.
  - Arbitration is not performed in RECOVER. A request sampled in RECOVER is served from IDLE on the next cycle.
- Outputs are registered from the next state:
  - `gnt = onehot(winner)`
  - `code = winner + 1`
  - Both are zero in IDLE and RECOVER.
- Reset (asynchronous, any state, including mid-grant):
  - state = IDLE; `gnt`, `code`, `busy` and `preempt` = 0.
  - `last_winner` = 2, so requester 0 has the highest priority first.
  - Hold counter = 0.
- Simultaneous requests: the round-robin order decides the winner. A requester that has just been served is lowest priority next time.
- `req` is assumed glitch-free and synchronous to `clock`. The arbiter does not synchronise it.

## Timing
- Grant latency: `req` rises in IDLE at edge n → `gnt`/`code` valid after edge n+1.
- Release latency: `req[winner]` falls before edge n → `gnt` = 0 after edge n.
  - RECOVER occupies the cycle after edge n.
  - Earliest next grant is after edge n+2.
- Back-to-back requester switch costs 2 idle cycles of `code` = 0.
- A grant has a minimum length of 1 cycle.
- A requester that drops and re-raises `req` in a single cycle is treated as a release followed by a new request.

## Configuration
- `MODE_ARB_HOLD_TIMER_EN` defined:
  - A 4-bit hold counter clears when a grant starts and increments each GRANT cycle.
  - The counter saturates at 15.
  - When count == `HOLD_MAX`-1 and any other `req` bit is high:
    - forced GRANT → RECOVER;
    - `preempt` pulses high for the same cycle in which `gnt` drops.
  - If no other requester is waiting, the grant continues past `HOLD_MAX`.
- `MODE_ARB_HOLD_TIMER_EN` undefined:
  - No counter is built; a grant lasts until the owner releases it.
  - `preempt` is constant 0.

## Structure
- Package `mode_arb_pkg` contains:
  - the state enum (IDLE, GRANT, RECOVER);
  - `CODE_IDLE` = 2'd0;
  - `NREQ` = 3;
  - the `code` width.
- Sub-module `rr_pick` is purely combinational:
  - inputs: `req` [2:0], `last` [1:0];
  - outputs: `win` [1:0], `any`.
- The FSM, the registers and the optional timer live in `mode_arbiter`.

## Test plan
- Reset behaviour:
  - Stimulus: assert `reset` low mid-grant with `req` = 3'b010.
  - Required response: `gnt`, `code` and `busy` = 0 immediately; after release, the first grant goes to requester 1.
- Single requester:
  - Stimulus: `req` = 3'b100 for 5 cycles, then 0.
  - Required response: `gnt` = 3'b100 and `code` = 3 one cycle after `req` rises; `gnt` = 0 one cycle after `req` falls; `busy` is low 2 cycles after the fall.
- Round-robin fairness:
  - Stimulus: `req` = 3'b111 held, each owner releasing after 2 cycles.
  - Required response: grant order 0, 1, 2, 0, with `code` = 0 for 2 cycles between grants.
- Simultaneous requests after wrap-around:
  - Stimulus: `last_winner` = 2, `req` = 3'b101.
  - Required response: requester 0 wins, then requester 2.
- Hold timer (`MODE_ARB_HOLD_TIMER_EN`, `HOLD_MAX` = 4):
  - Stimulus: requester 0 holds `req`, and requester 1 requests at grant cycle 2.
  - Required response: after 4 grant cycles, `preempt` pulses and `gnt` drops; requester 1 is granted 2 cycles later.
- Hold timer compiled out:
  - Stimulus: the same as the hold-timer scenario.
  - Required response: requester 0 keeps the grant indefinitely; `preempt` stays 0.
